// File: rtl/uart16_pkg.sv
// Shared definitions for the UART byte streamers (RX unpacker and TX streamer).
// Both ends import the default transfer length so they agree on frame size.
package uart16_pkg;

  localparam int DEFAULT_NUM_BYTES = 8192;
  localparam int DEFAULT_ADDR_W    = 14;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/uart_cksum8.sv
// Modulo-256 byte accumulator with synchronous clear; shared by the RX and TX sides.
module uart_cksum8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  logic [7:0] sum_d, sum_q;

  always_comb begin
    sum_d = sum_q;
    if (clear)   sum_d = 8'h00;
    else if (en) sum_d = sum_q + din;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= 8'h00;
    else     sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/uart_rx_unpack16.sv
// Packs received UART bytes little-endian into 16-bit words and writes them to memory.
// Optional byte checksum output enabled by defining UART_RX_UNPACK16_CKSUM_EN.
module uart_rx_unpack16
  import uart16_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
  parameter int ADDR_W    = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rearm,
  input  logic              uart_valid,
  input  logic [7:0]        uart_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef UART_RX_UNPACK16_CKSUM_EN
  ,
  output logic [7:0]        cksum
`endif
);

  // One extra counter bit so the terminal count NUM_BYTES/2 is representable.
  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_BYTES / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [7:0]        low_d, low_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [15:0]       wdata_d, wdata_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              ovf_d, ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    low_d   = low_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_LOW: begin
        if (uart_valid) begin
          low_d   = uart_data;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (uart_valid) begin
          wdata_d = {uart_data, low_q};
          addr_d  = cnt_q[ADDR_W-1:0];
          we_d    = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == LAST_WORD) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_LOW;
          end
        end
      end
      S_DONE: begin
        // rearm takes priority over a coincident byte, which is simply dropped.
        if (rearm) begin
          state_d = S_LOW;
          cnt_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
        end else if (uart_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      low_q   <= 8'h00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

`ifdef UART_RX_UNPACK16_CKSUM_EN
  logic cksum_en, cksum_clr;

  assign cksum_en  = uart_valid && (state_q != S_DONE);
  assign cksum_clr = rearm && (state_q == S_DONE);

  uart_cksum8 u_cksum (
    .clk   (clk),
    .rst   (rst),
    .clear (cksum_clr),
    .en    (cksum_en),
    .din   (uart_data),
    .sum   (cksum)
  );
`endif

endmodule

// File: tb/tb_uart_rx_unpack16.sv
// Directed self-checking bench for uart_rx_unpack16 (NUM_BYTES=8; a NUM_BYTES=4
// instance exercises the checksum when UART_RX_UNPACK16_CKSUM_EN is defined).
module tb_uart_rx_unpack16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rearm = 1'b0;
  logic        uart_valid = 1'b0;
  logic [7:0]  uart_data = 8'h00;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy, done, overflow;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [2:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  always #5 clk = ~clk;

`ifdef UART_RX_UNPACK16_CKSUM_EN
  logic [7:0] cksum;
  logic       we4, busy4, done4, ovf4;
  logic [0:0] addr4;
  logic [15:0] wdata4;
  logic [7:0] cksum4;
`endif

  uart_rx_unpack16 #(.NUM_BYTES(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .rearm      (rearm),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
`ifdef UART_RX_UNPACK16_CKSUM_EN
    ,
    .cksum      (cksum)
`endif
  );

`ifdef UART_RX_UNPACK16_CKSUM_EN
  uart_rx_unpack16 #(.NUM_BYTES(4), .ADDR_W(1)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .rearm      (rearm),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .mem_we     (we4),
    .mem_addr   (addr4),
    .mem_wdata  (wdata4),
    .busy       (busy4),
    .done       (done4),
    .overflow   (ovf4),
    .cksum      (cksum4)
  );
`endif

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    uart_valid = 1'b1;
    uart_data  = b;
    tick();
    uart_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_compared++;
    if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_we: got %b want 0", mem_we); end
    n_compared++;
    if (mem_addr !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_addr: got %0d want 0", mem_addr); end
    n_compared++;
    if (mem_wdata !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_wdata: got %h want 0000", mem_wdata); end
    n_compared++;
    if ({busy, done, overflow} !== 3'b100) begin n_mismatched++; $display("[TB] FAIL reset_flags: got busy/done/ovf=%b want 100", {busy, done, overflow}); end
  endtask

  task automatic test_single_word();
    send(8'h34);
    n_compared++;
    if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL low_no_we: got %b want 0", mem_we); end
    send(8'h12);
    n_compared++;
    if (mem_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL word_we: got %b want 1", mem_we); end
    n_compared++;
    if (mem_addr !== 3'd0) begin n_mismatched++; $display("[TB] FAIL word_addr: got %0d want 0", mem_addr); end
    n_compared++;
    if (mem_wdata !== 16'h1234) begin n_mismatched++; $display("[TB] FAIL word_data: got %h want 1234", mem_wdata); end
    n_compared++;
    if ({busy, done} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL word_flags: got busy/done=%b want 10", {busy, done}); end
    tick();
    n_compared++;
    if (mem_we !== 1'b0 || mem_wdata !== 16'h1234) begin n_mismatched++; $display("[TB] FAIL word_hold: got we=%b data=%h want we=0 data=1234", mem_we, mem_wdata); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_data[4];
    exp_data = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
    do_reset();
    for (int i = 0; i < 8; i++) send(8'(i));
    n_compared++;
    if (mem_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_last_we: got %b want 1", mem_we); end
    tick();
    n_compared++;
    if ({busy, done, mem_we} !== 3'b010) begin n_mismatched++; $display("[TB] FAIL b2b_done: got busy/done/we=%b want 010", {busy, done, mem_we}); end
    n_compared++;
    if (wr_addr_q.size() !== 4) begin
      n_mismatched++; $display("[TB] FAIL b2b_count: got %0d writes want 4", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_compared++;
        if (wr_addr_q[i] !== 3'(i) || wr_data_q[i] !== exp_data[i]) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_word%0d: got addr=%0d data=%h want addr=%0d data=%h", i, wr_addr_q[i], wr_data_q[i], i, exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_overflow_rearm();
    wr_addr_q.delete();
    wr_data_q.delete();
    send(8'hAA);
    tick();
    n_compared++;
    if (wr_addr_q.size() !== 0) begin n_mismatched++; $display("[TB] FAIL ovf_no_write: got %0d writes want 0", wr_addr_q.size()); end
    n_compared++;
    if ({overflow, done} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL ovf_flag: got ovf/done=%b want 11", {overflow, done}); end
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    n_compared++;
    if ({busy, done, overflow} !== 3'b100) begin n_mismatched++; $display("[TB] FAIL rearm_flags: got busy/done/ovf=%b want 100", {busy, done, overflow}); end
    send(8'h11);
    send(8'h22);
    n_compared++;
    if (mem_we !== 1'b1 || mem_addr !== 3'd0 || mem_wdata !== 16'h2211) begin
      n_mismatched++; $display("[TB] FAIL rearm_word: got we=%b addr=%0d data=%h want we=1 addr=0 data=2211", mem_we, mem_addr, mem_wdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    send(8'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    n_compared++;
    if (mem_we !== 1'b0 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_state: got we=%b busy=%b want we=0 busy=1", mem_we, busy); end
    send(8'h66);
    send(8'h77);
    tick();
    tick();
    n_compared++;
    if (wr_addr_q.size() !== 1) begin
      n_mismatched++; $display("[TB] FAIL midrst_count: got %0d writes want 1", wr_addr_q.size());
    end else begin
      n_compared++;
      if (wr_addr_q[0] !== 3'd0 || wr_data_q[0] !== 16'h7766) begin
        n_mismatched++; $display("[TB] FAIL midrst_word: got addr=%0d data=%h want addr=0 data=7766", wr_addr_q[0], wr_data_q[0]);
      end
    end
  endtask

  task automatic test_rearm_with_byte();
    do_reset();
    for (int i = 1; i <= 8; i++) send(8'(i));
    tick();
    wr_addr_q.delete();
    wr_data_q.delete();
    rearm = 1'b1;
    uart_valid = 1'b1;
    uart_data = 8'hEE;
    tick();
    rearm = 1'b0;
    uart_valid = 1'b0;
    n_compared++;
    if ({busy, done, overflow} !== 3'b100) begin n_mismatched++; $display("[TB] FAIL rearm_byte_flags: got busy/done/ovf=%b want 100", {busy, done, overflow}); end
    send(8'h3C);
    send(8'hC3);
    tick();
    n_compared++;
    if (wr_addr_q.size() !== 1) begin
      n_mismatched++; $display("[TB] FAIL rearm_byte_count: got %0d writes want 1", wr_addr_q.size());
    end else begin
      n_compared++;
      if (wr_addr_q[0] !== 3'd0 || wr_data_q[0] !== 16'hC33C) begin
        n_mismatched++; $display("[TB] FAIL rearm_byte_word: got addr=%0d data=%h want addr=0 data=c33c", wr_addr_q[0], wr_data_q[0]);
      end
    end
  endtask

`ifdef UART_RX_UNPACK16_CKSUM_EN
  task automatic test_cksum();
    do_reset();
    send(8'hFF);
    n_compared++;
    if (cksum4 !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL cksum_first: got %h want ff", cksum4); end
    send(8'h01);
    send(8'h80);
    send(8'h80);
    tick();
    n_compared++;
    if (cksum4 !== 8'h00 || done4 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL cksum_final: got cksum=%h done=%b want 00/1", cksum4, done4); end
    send(8'h05);
    tick();
    n_compared++;
    if (cksum4 !== 8'h00 || ovf4 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL cksum_ovf: got cksum=%h ovf=%b want 00/1", cksum4, ovf4); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow_rearm();
    test_reset_mid();
    test_rearm_with_byte();
`ifdef UART_RX_UNPACK16_CKSUM_EN
    test_cksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
